// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch run-control sequencer and its surroundings
// (buttons, time-base divider, elapsed-time counter, display driver).
interface stopwatch_ctrl_if #(
    parameter int TIME_WIDTH = 16
);
    logic                  btn_ss;
    logic                  btn_lr;
    logic                  tick;
    logic [TIME_WIDTH-1:0] time_in;
    logic                  tb_rst;
    logic                  cnt_en;
    logic                  cnt_clr;
    logic [TIME_WIDTH-1:0] disp;
    logic [1:0]            state;
    logic                  lap_active;

    modport master (
        output btn_ss, btn_lr, tick, time_in,
        input  tb_rst, cnt_en, cnt_clr, disp, state, lap_active
    );

    modport slave (
        input  btn_ss, btn_lr, tick, time_in,
        output tb_rst, cnt_en, cnt_clr, disp, state, lap_active
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control: button sync/edge detect, start/stop/lap/reset FSM,
// tick gating, counter clear and the lap-freezing display register.
module stopwatch_ctrl #(
    parameter int TIME_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    state_t                cur;
    state_t                nxt;
    logic [1:0]            ss_sync;
    logic [1:0]            lr_sync;
    logic                  ss_prev;
    logic                  lr_prev;
    logic                  ss_p;
    logic                  lr_p;
    logic                  lap_load;
    logic                  clr_set;
    logic                  clr_p0;
    logic                  clr_p1;
    logic [TIME_WIDTH-1:0] lap_reg;
    logic [TIME_WIDTH-1:0] disp_p0;

    // Synchronizers and prev flops reset high so a button held through reset stays silent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync <= 2'b11;
            lr_sync <= 2'b11;
            ss_prev <= 1'b1;
            lr_prev <= 1'b1;
        end else begin
            ss_sync <= {ss_sync[0], bus.btn_ss};
            lr_sync <= {lr_sync[0], bus.btn_lr};
            ss_prev <= ss_sync[1];
            lr_prev <= lr_sync[1];
        end
    end

    assign ss_p = ss_sync[1] & ~ss_prev;
    assign lr_p = lr_sync[1] & ~lr_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= IDLE;
        else     cur <= nxt;
    end

    // Start/stop wins over lap/reset when both pulse together.
    always_comb begin
        nxt      = cur;
        lap_load = 1'b0;
        clr_set  = 1'b0;
        case (cur)
            IDLE: begin
                if (ss_p)      nxt = RUN;
                else if (lr_p) clr_set = 1'b1;
            end
            RUN: begin
                if (ss_p) nxt = PAUSE;
                else if (lr_p) begin
                    nxt      = LAP;
                    lap_load = 1'b1;
                end
            end
            LAP: begin
                if (ss_p)      nxt = PAUSE;
                else if (lr_p) nxt = RUN;
            end
            PAUSE: begin
                if (ss_p) nxt = RUN;
                else if (lr_p) begin
                    nxt     = IDLE;
                    clr_set = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.tb_rst     = 1'b1;
        bus.cnt_en     = 1'b0;
        bus.lap_active = 1'b0;
        case (cur)
            RUN: begin
                bus.tb_rst = 1'b0;
                bus.cnt_en = bus.tick;
            end
            LAP: begin
                bus.tb_rst     = 1'b0;
                bus.cnt_en     = bus.tick;
                bus.lap_active = 1'b1;
            end
            default: ;
        endcase
    end

    // Clear request is staged twice so the pulse lands one cycle after IDLE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_p0 <= 1'b0;
            clr_p1 <= 1'b0;
        end else begin
            clr_p0 <= clr_set;
            clr_p1 <= clr_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_reg <= '0;
            disp_p0 <= '0;
        end else begin
            if (lap_load) lap_reg <= bus.time_in;
            disp_p0 <= (cur == LAP) ? lap_reg : bus.time_in;
        end
    end

    assign bus.cnt_clr = clr_p1;
    assign bus.disp    = disp_p0;
    assign bus.state   = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: a cycle table for the main flows plus
// hand sequences for reset behaviour and held buttons.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    stopwatch_ctrl_if #(.TIME_WIDTH(16)) bus ();

    stopwatch_ctrl #(.TIME_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ss;
        logic        lr;
        logic        tick;
        logic [15:0] tin;
        logic [1:0]  st;
        logic        tbr;
        logic        en;
        logic        clr;
        logic [15:0] disp;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic ss, input logic lr, input logic tick, input logic [15:0] tin,
                       input logic [1:0] st, input logic tbr, input logic en, input logic clr,
                       input logic [15:0] disp);
        vec_t v;
        v.ss = ss; v.lr = lr; v.tick = tick; v.tin = tin;
        v.st = st; v.tbr = tbr; v.en = en; v.clr = clr; v.disp = disp;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_state"}, 32'(bus.state), 32'd0);
        check({name, "_tb_rst"}, 32'(bus.tb_rst), 32'd1);
        check({name, "_cnt_en"}, 32'(bus.cnt_en), 32'd0);
        check({name, "_cnt_clr"}, 32'(bus.cnt_clr), 32'd0);
        check({name, "_disp"}, 32'(bus.disp), 32'd0);
        check({name, "_lap"}, 32'(bus.lap_active), 32'd0);
    endtask

    task automatic wait_state(input string name, input logic [1:0] target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (bus.state == target) break;
        end
        check(name, 32'(bus.state), 32'(target));
    endtask

    initial begin
        bus.btn_ss  = 1'b0;
        bus.btn_lr  = 1'b0;
        bus.tick    = 1'b0;
        bus.time_in = 16'h0000;

        // Columns: ss lr tick time_in | state tb_rst cnt_en cnt_clr disp
        add(0,0,1,16'h0010, 2'd0,1,0,0,16'h0000);
        add(1,0,0,16'h0010, 2'd0,1,0,0,16'h0010);
        add(1,0,0,16'h0010, 2'd0,1,0,0,16'h0010);
        add(1,0,0,16'h0010, 2'd0,1,0,0,16'h0010);
        add(0,0,1,16'h0011, 2'd1,0,1,0,16'h0010);
        add(0,0,0,16'h0012, 2'd1,0,0,0,16'h0011);
        add(0,0,1,16'h0042, 2'd1,0,1,0,16'h0012);
        add(0,1,0,16'h0042, 2'd1,0,0,0,16'h0042);
        add(0,1,0,16'h0042, 2'd1,0,0,0,16'h0042);
        add(0,1,0,16'h0042, 2'd1,0,0,0,16'h0042);
        add(0,0,1,16'h0043, 2'd3,0,1,0,16'h0042);
        add(0,0,0,16'h0044, 2'd3,0,0,0,16'h0042);
        add(0,0,0,16'h0045, 2'd3,0,0,0,16'h0042);
        add(0,1,0,16'h0046, 2'd3,0,0,0,16'h0042);
        add(0,1,0,16'h0047, 2'd3,0,0,0,16'h0042);
        add(0,0,0,16'h0048, 2'd3,0,0,0,16'h0042);
        add(0,0,0,16'h0049, 2'd1,0,0,0,16'h0042);
        add(0,0,0,16'h004A, 2'd1,0,0,0,16'h0049);
        add(1,0,1,16'h004B, 2'd1,0,1,0,16'h004A);
        add(0,0,0,16'h004C, 2'd1,0,0,0,16'h004B);
        add(0,0,0,16'h004C, 2'd1,0,0,0,16'h004C);
        add(0,0,1,16'h004C, 2'd2,1,0,0,16'h004C);
        add(0,1,1,16'h004C, 2'd2,1,0,0,16'h004C);
        add(0,0,0,16'h004C, 2'd2,1,0,0,16'h004C);
        add(0,0,0,16'h004C, 2'd2,1,0,0,16'h004C);
        add(0,0,0,16'h004C, 2'd0,1,0,0,16'h004C);
        add(0,0,0,16'h0000, 2'd0,1,0,1,16'h004C);
        add(0,0,0,16'h0000, 2'd0,1,0,0,16'h0000);
        add(1,0,0,16'h0000, 2'd0,1,0,0,16'h0000);
        add(0,0,0,16'h0000, 2'd0,1,0,0,16'h0000);
        add(0,0,0,16'h0000, 2'd0,1,0,0,16'h0000);
        add(0,0,0,16'h0077, 2'd1,0,0,0,16'h0000);
        add(1,1,0,16'h0078, 2'd1,0,0,0,16'h0077);
        add(0,0,0,16'h0079, 2'd1,0,0,0,16'h0078);
        add(0,0,1,16'h0079, 2'd1,0,1,0,16'h0079);
        add(0,0,1,16'h0079, 2'd2,1,0,0,16'h0079);
        add(0,0,0,16'h0079, 2'd2,1,0,0,16'h0079);
        add(0,0,0,16'h0079, 2'd2,1,0,0,16'h0079);

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.tick = 1'b1;
        #1 check_reset_vals("in_reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.tick = i[0];
            #1;
            check("idle_state", 32'(bus.state), 32'd0);
            check("idle_cnt_en", 32'(bus.cnt_en), 32'd0);
            check("idle_disp", 32'(bus.disp), 32'd0);
        end

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            bus.btn_ss  = vq[i].ss;
            bus.btn_lr  = vq[i].lr;
            bus.tick    = vq[i].tick;
            bus.time_in = vq[i].tin;
            #1;
            check($sformatf("v%0d_state", i), 32'(bus.state), 32'(vq[i].st));
            check($sformatf("v%0d_tb_rst", i), 32'(bus.tb_rst), 32'(vq[i].tbr));
            check($sformatf("v%0d_cnt_en", i), 32'(bus.cnt_en), 32'(vq[i].en));
            check($sformatf("v%0d_cnt_clr", i), 32'(bus.cnt_clr), 32'(vq[i].clr));
            check($sformatf("v%0d_disp", i), 32'(bus.disp), 32'(vq[i].disp));
            check($sformatf("v%0d_lap", i), 32'(bus.lap_active), 32'(vq[i].st == 2'd3));
        end

        // Start/stop held high across reset release: no pulse until released and pressed again.
        @(negedge clk);
        bus.btn_ss = 1'b1;
        bus.btn_lr = 1'b0;
        bus.tick   = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("held_no_pulse", 32'(bus.state), 32'd0);
        end
        bus.btn_ss = 1'b0;
        repeat (3) @(negedge clk);
        bus.btn_ss = 1'b1;
        wait_state("repress_run", 2'd1, 8);

        // Reset asserted mid-LAP clears every output without waiting for a clock.
        bus.btn_ss  = 1'b0;
        bus.time_in = 16'h1234;
        bus.btn_lr  = 1'b1;
        wait_state("enter_lap", 2'd3, 8);
        bus.time_in = 16'h1300;
        @(negedge clk); #1;
        check("lap_disp", 32'(bus.disp), 32'h1234);
        bus.tick = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        bus.btn_lr = 1'b0;
        bus.tick   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout reached=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule
